add4_sched: RTL and testbench
=============================

# add4_sched

Sequencer and arbiter for a shared combinational 4-bit adder slice (`add4`: `a`, `b`, `cin` -> `sum`, `cout`). Two requesters submit wide additions of 4*NIB bits. The block grants one requester round-robin and runs the operands through the external adder one nibble per cycle, least-significant nibble first, chaining the carry. It returns the full sum and carry-out on a valid/ready response channel. It sits between the client logic and a single `add4` instance.

## Interface
- NIB, 4, number of nibbles per operand; operand width W = 4*NIB; NIB >= 1
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- req0_valid / req1_valid  input  1  request present
- req0_ready / req1_ready  output  1  request accepted on this edge when valid
- req0_a, req0_b / req1_a, req1_b  input  W  operands
- req0_cin / req1_cin  input  1  carry-in
- resp_valid  output  1  result present
- resp_ready  input  1  consumer accepts the result
- resp_id  output  1  index of the requester served
- resp_sum  output  W  sum
- resp_cout  output  1  final carry-out
- add_a, add_b  output  4  nibble operands to the adder
- add_cin  output  1  carry-in to the adder
- add_sum  input  4  adder sum
- add_cout  input  1  adder carry-out

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - The grant goes to the only valid requester.
  - If both requesters are valid, the grant goes to the one not served last. A last-served pointer records this and resets to 1, so req0 wins the first tie.
  - reqN_ready = (state==IDLE) && grant==N. Ready is combinational on both valids. Requesters must not gate valid on ready.
  - On handshake: latch a, b, cin and the id; set nibble index k=0, carry=cin; go to RUN.
- RUN, each cycle:
  - add_a = a[4k+3:4k], add_b = b[4k+3:4k], add_cin = carry.
  - At the edge: sum[4k+3:4k] <= add_sum; carry <= add_cout; k <= k+1.
  - After the edge with k=NIB-1, go to DONE.
- DONE:
  - resp_valid=1. resp_sum, resp_cout and resp_id are held stable.
  - On the resp_valid && resp_ready edge: update the last-served pointer, go to IDLE.
- Outside RUN, add_a, add_b and add_cin are driven to 0.
- Arithmetic is unsigned modulo 2^W. resp_cout = bit W of a+b+cin.
- No new request is accepted before the response handshake completes; there is no queuing.

## Timing
- Reset values:
  - State IDLE; k=0; last-served=1.
  - resp_valid=0, resp_id=0, resp_sum=0, resp_cout=0.
  - add_a=0, add_b=0, add_cin=0.
  - req0_ready and req1_ready are 0 unless the matching valid is high (IDLE ready rule).
- Latency: with the accept at edge E0, resp_valid is high from edge E_NIB onward. The adder is driven during the NIB cycles between E0 and E_NIB.
- Throughput: with resp_ready held at 1, one operation per NIB+2 cycles.
- Backpressure: resp_ready=0 holds DONE indefinitely. Both readys stay 0 meanwhile.
- Simultaneous valids: exactly one ready is high in a cycle, never both.
- Reset mid-RUN or mid-DONE: the operation is discarded, no response is produced, and the block returns to IDLE immediately (asynchronous).
- NIB=1: RUN lasts one cycle.

## Configuration
- Macro: ADD4_SCHED_SUB_EN.
- Defined:
  - Adds ports req0_sub and req1_sub (input, 1 bit), latched at accept.
  - When sub=1, every nibble uses add_b = ~b nibble, and the initial carry is 1 (reqN_cin is ignored).
  - The result is a-b mod 2^W. resp_cout=1 means no borrow.
  - When sub=0, behaviour is identical to the undefined case.
- Undefined: the sub ports do not exist; the block is add-only.

## Test plan
All scenarios use NIB=4.
- Basic add: req0 a=0x0001 b=0x0002 cin=0 with resp_ready=1 -> resp_sum=0x0003, resp_cout=0, resp_id=0. resp_valid is high exactly 4 edges after the accept edge.
- Full carry chain: req1 a=0xFFFF b=0x0001 cin=0 -> resp_sum=0x0000, resp_cout=1, resp_id=1. Separately, a=0xA5A5 b=0x5A5A cin=1 -> resp_sum=0x0000, resp_cout=1.
- Round-robin: after reset both valid and held -> served in order req0, req1, req0, req1. req0_ready and req1_ready are never high in the same cycle.
- Backpressure: resp_ready=0 for 10 cycles in DONE -> resp_valid, resp_sum and resp_id stay constant and both readys stay 0. Raising resp_ready gives one handshake, then IDLE.
- Reset mid-RUN: assert rst during the 2nd RUN cycle -> no resp_valid. The next request completes correctly with the original latency and req0 priority.
- ADD4_SCHED_SUB_EN defined:
  - a=0x0005 b=0x0003 sub=1 -> resp_sum=0x0002, resp_cout=1.
  - a=0x0003 b=0x0005 sub=1 -> resp_sum=0xFFFE, resp_cout=0.

Source files
------------

// File: rtl/add4_sched.sv
// add4_sched: round-robin sequencer that pushes two requesters' wide additions
// through one shared 4-bit adder slice, one nibble per cycle, LS nibble first.
// Optional build macro ADD4_SCHED_SUB_EN adds per-request subtract mode
// (a - b via ~b nibbles and a forced initial carry of 1).
module add4_sched #(
  parameter int unsigned NIB = 4
) (
  input  logic               clk,
  input  logic               rst,
  // requester 0
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [4*NIB-1:0]   req0_a,
  input  logic [4*NIB-1:0]   req0_b,
  input  logic               req0_cin,
`ifdef ADD4_SCHED_SUB_EN
  input  logic               req0_sub,
`endif
  // requester 1
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [4*NIB-1:0]   req1_a,
  input  logic [4*NIB-1:0]   req1_b,
  input  logic               req1_cin,
`ifdef ADD4_SCHED_SUB_EN
  input  logic               req1_sub,
`endif
  // response channel
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic [4*NIB-1:0]   resp_sum,
  output logic               resp_cout,
  // shared adder slice
  output logic [3:0]         add_a,
  output logic [3:0]         add_b,
  output logic               add_cin,
  input  logic [3:0]         add_sum,
  input  logic               add_cout
);

  localparam int unsigned W  = 4 * NIB;
  localparam int unsigned KW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;
  logic            r_carry;
  logic            r_id;
  logic            r_last;
  logic            r_sub;
  logic [KW-1:0]   r_k;

  logic [KW+1:0]   w_base;
  logic [3:0]      w_nib_a;
  logic [3:0]      w_nib_b;
  logic            w_grant;
  logic            w_accept;
  logic            w_last_nib;
  logic            w_sub_sel;
  logic            w_cin_sel;

  // Bit offset of the current nibble and the operand nibbles it selects.
  assign w_base     = {r_k, 2'b00};
  assign w_nib_a    = r_a[w_base +: 4];
  assign w_nib_b    = r_b[w_base +: 4];
  assign w_last_nib = (r_k == KW'(NIB - 1));

`ifdef ADD4_SCHED_SUB_EN
  assign w_sub_sel = w_grant ? req1_sub : req0_sub;
`else
  assign w_sub_sel = 1'b0;
`endif

  // Subtract forces the initial carry to 1 (two's complement of b).
  assign w_cin_sel = w_sub_sel ? 1'b1 : (w_grant ? req1_cin : req0_cin);

  // Grant: sole valid requester wins; on a tie the one not served last wins.
  always_comb begin
    w_grant = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant = ~r_last;
    end else if (req1_valid) begin
      w_grant = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, handshake readys and adder drive.
  always_comb begin
    w_state_nxt = r_state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp_valid  = 1'b0;
    add_a       = 4'h0;
    add_b       = 4'h0;
    add_cin     = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        req0_ready = req0_valid && !w_grant;
        req1_ready = req1_valid &&  w_grant;
        w_accept   = req0_ready || req1_ready;
        if (w_accept) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        add_a   = w_nib_a;
        add_b   = r_sub ? ~w_nib_b : w_nib_b;
        add_cin = r_carry;
        if (w_last_nib) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture, nibble-serial accumulation and last-served tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_id    <= 1'b0;
      r_last  <= 1'b1;
      r_sub   <= 1'b0;
      r_k     <= '0;
    end else if (w_accept) begin
      r_a     <= w_grant ? req1_a : req0_a;
      r_b     <= w_grant ? req1_b : req0_b;
      r_carry <= w_cin_sel;
      r_sub   <= w_sub_sel;
      r_id    <= w_grant;
      r_k     <= '0;
    end else if (r_state == RUN) begin
      r_sum[w_base +: 4] <= add_sum;
      r_carry            <= add_cout;
      r_k                <= w_last_nib ? '0 : (r_k + KW'(1));
    end else if ((r_state == DONE) && resp_ready) begin
      r_last <= r_id;
    end
  end

  // Response fields are held in registers until the next operation overwrites them.
  assign resp_id   = r_id;
  assign resp_sum  = r_sum;
  assign resp_cout = r_carry;

endmodule

// File: tb/tb_add4_sched.sv
// tb_add4_sched: scenario bench for add4_sched with a behavioural add4 slice
// and a scoreboard of expected responses. Define ADD4_SCHED_SUB_EN to also
// exercise subtract mode.
module tb_add4_sched;

  localparam int unsigned NIB = 4;
  localparam int unsigned W   = 4 * NIB;

  typedef struct packed {
    logic         id;
    logic         cout;
    logic [W-1:0] sum;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_cin, req1_cin;
`ifdef ADD4_SCHED_SUB_EN
  logic         req0_sub, req1_sub;
`endif
  logic         resp_valid, resp_ready, resp_id, resp_cout;
  logic [W-1:0] resp_sum;
  logic [3:0]   add_a, add_b, add_sum;
  logic         add_cin, add_cout;
  logic [4:0]   w_add;

  int   n_pass  = 0;
  int   n_total = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Behavioural add4 slice.
  assign w_add    = 5'(add_a) + 5'(add_b) + 5'(add_cin);
  assign add_sum  = w_add[3:0];
  assign add_cout = w_add[4];

  add4_sched #(.NIB(NIB)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
`ifdef ADD4_SCHED_SUB_EN
    .req0_sub   (req0_sub),
`endif
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
`ifdef ADD4_SCHED_SUB_EN
    .req1_sub   (req1_sub),
`endif
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .resp_cout  (resp_cout),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_cin    (add_cin),
    .add_sum    (add_sum),
    .add_cout   (add_cout)
  );

  function automatic exp_t mk(input logic id, input logic [W-1:0] sum, input logic cout);
    exp_t e;
    e.id   = id;
    e.sum  = sum;
    e.cout = cout;
    return e;
  endfunction

  // Reference: full-width unsigned a + b + cin (or a - b as a + ~b + 1).
  function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    logic [W:0] t;
    if (sub) t = (W+1)'(a) + (W+1)'(~b) + (W+1)'(1'b1);
    else     t = (W+1)'(a) + (W+1)'(b)  + (W+1)'(cin);
    return mk(id, t[W-1:0], t[W]);
  endfunction

  // Present one request and return right after its accept edge (+1).
  task automatic send(input logic n, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    if (n) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin;
    end
    #1;
    for (int i = 0; i < 40; i++) begin
      if (n ? req1_ready : req0_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (ok) @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Count edges until resp_valid is seen, bounded.
  task automatic wait_resp(output bit got, output int cyc);
    got = 1'b0;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (resp_valid) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    #2;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_a = '0; req1_b = '0; req1_cin = 1'b0;
`ifdef ADD4_SCHED_SUB_EN
    req0_sub = 1'b0; req1_sub = 1'b0;
`endif
    resp_ready = 1'b0;
    #12;
    n_total++;
    if ({resp_valid, resp_id, resp_cout, resp_sum, add_a, add_b, add_cin, req0_ready, req1_ready} !== '0)
      $display("FAIL reset_outputs: valid=%b id=%b cout=%b sum=%h add=%h/%h/%b rdy=%b%b, all required 0",
               resp_valid, resp_id, resp_cout, resp_sum, add_a, add_b, add_cin, req0_ready, req1_ready);
    else n_pass++;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    n_total++;
    if ({req0_ready, req1_ready} !== 2'b10)
      $display("FAIL reset_tie_priority: rdy0/rdy1=%b%b required 10", req0_ready, req1_ready);
    else n_pass++;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_add;
    bit ok, got;
    int cyc;
    exp_t e;
    resp_ready = 1'b1;
    sb.delete();
    send(1'b0, 16'h0001, 16'h0002, 1'b0, ok);
    if (ok) sb.push_back(mk(1'b0, 16'h0003, 1'b0));
    n_total++;
    if (!ok) $display("FAIL basic_accept: req0_ready never high, required high");
    else n_pass++;
    wait_resp(got, cyc);
    n_total++;
    if (!got || cyc != 4) $display("FAIL basic_latency: got=%0b edges=%0d required 1/4", got, cyc);
    else n_pass++;
    e = (sb.size() > 0) ? sb.pop_front() : mk(1'b1, 16'hDEAD, 1'b1);
    n_total++;
    if (resp_sum !== e.sum || resp_cout !== e.cout || resp_id !== e.id)
      $display("FAIL basic_result: sum=%h cout=%b id=%b required %h/%b/%b",
               resp_sum, resp_cout, resp_id, e.sum, e.cout, e.id);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if (resp_valid !== 1'b0) $display("FAIL basic_handshake: resp_valid=%b required 0", resp_valid);
    else n_pass++;
  endtask

  task automatic test_carry_chain;
    logic [W-1:0] ta[2] = '{16'hFFFF, 16'hA5A5};
    logic [W-1:0] tb[2] = '{16'h0001, 16'h5A5A};
    logic         tc[2] = '{1'b0, 1'b1};
    bit ok, got;
    int cyc;
    exp_t e;
    resp_ready = 1'b1;
    sb.delete();
    for (int i = 0; i < 2; i++) begin
      send(1'b1, ta[i], tb[i], tc[i], ok);
      if (ok) sb.push_back(mk(1'b1, 16'h0000, 1'b1));
      wait_resp(got, cyc);
      e = (sb.size() > 0) ? sb.pop_front() : mk(1'b0, 16'hDEAD, 1'b0);
      n_total++;
      if (!ok || !got || resp_sum !== e.sum || resp_cout !== e.cout || resp_id !== e.id)
        $display("FAIL carry_chain_%0d: ok=%0b got=%0b sum=%h cout=%b id=%b required %h/%b/%b",
                 i, ok, got, resp_sum, resp_cout, resp_id, e.sum, e.cout, e.id);
      else n_pass++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_round_robin;
    int   n_resp = 0;
    int   both = 0;
    int   last_cyc = -1;
    exp_t e;
    do_reset();
    sb.delete();
    resp_ready = 1'b1;
    req0_a = 16'h1234; req0_b = 16'h1111; req0_cin = 1'b0;
    req1_a = 16'hF000; req1_b = 16'h2000; req1_cin = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int cyc = 0; cyc < 80 && n_resp < 4; cyc++) begin
      #1;
      if (req0_ready && req1_ready) both++;
      if (req0_ready) sb.push_back(model(1'b0, req0_a, req0_b, req0_cin, 1'b0));
      if (req1_ready) sb.push_back(model(1'b1, req1_a, req1_b, req1_cin, 1'b0));
      if (resp_valid && resp_ready) begin
        e = (sb.size() > 0) ? sb.pop_front() : mk(1'b0, 16'hDEAD, 1'b0);
        n_total++;
        if (resp_id !== 1'(n_resp % 2) || resp_sum !== e.sum || resp_cout !== e.cout)
          $display("FAIL rr_order_%0d: id=%b sum=%h cout=%b required %0d/%h/%b",
                   n_resp, resp_id, resp_sum, resp_cout, n_resp % 2, e.sum, e.cout);
        else n_pass++;
        if (last_cyc >= 0) begin
          n_total++;
          if (cyc - last_cyc != int'(NIB) + 2)
            $display("FAIL rr_throughput_%0d: spacing=%0d required %0d", n_resp, cyc - last_cyc, NIB + 2);
          else n_pass++;
        end
        last_cyc = cyc;
        n_resp++;
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_total++;
    if (n_resp != 4) $display("FAIL rr_count: responses=%0d required 4", n_resp);
    else n_pass++;
    n_total++;
    if (both != 0) $display("FAIL rr_exclusive_ready: both-ready cycles=%0d required 0", both);
    else n_pass++;
  endtask

  task automatic test_backpressure;
    bit ok, got;
    int cyc;
    int bad = 0;
    exp_t e;
    sb.delete();
    resp_ready = 1'b0;
    send(1'b0, 16'h00FF, 16'h0F0F, 1'b0, ok);
    if (ok) sb.push_back(mk(1'b0, 16'h100E, 1'b0));
    wait_resp(got, cyc);
    n_total++;
    if (!ok || !got) $display("FAIL bp_response: ok=%0b got=%0b required 1/1", ok, got);
    else n_pass++;
    e = (sb.size() > 0) ? sb.pop_front() : mk(1'b1, 16'hDEAD, 1'b1);
    req1_a = 16'h0001; req1_b = 16'h0001; req1_cin = 1'b0;
    req1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      n_total++;
      if (resp_valid !== 1'b1 || resp_sum !== e.sum || resp_id !== e.id || resp_cout !== e.cout ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        $display("FAIL bp_hold_%0d: valid=%b sum=%h id=%b rdy=%b%b required 1/%h/%b/00",
                 i, resp_valid, resp_sum, resp_id, req0_ready, req1_ready, e.sum, e.id);
        bad++;
      end else n_pass++;
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    n_total++;
    if (resp_valid !== 1'b0 || req1_ready !== 1'b1)
      $display("FAIL bp_release: resp_valid=%b req1_ready=%b required 0/1", resp_valid, req1_ready);
    else n_pass++;
    req1_valid = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    bit ok, got;
    int cyc;
    int seen = 0;
    exp_t e;
    resp_ready = 1'b1;
    sb.delete();
    send(1'b1, 16'h4321, 16'h2222, 1'b0, ok);
    @(posedge clk);
    #2;
    n_total++;
    if (!ok || add_a !== 4'h2 || add_b !== 4'h2)
      $display("FAIL midrun_drive: ok=%0b add_a=%h add_b=%h required 1/2/2", ok, add_a, add_b);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if (add_a !== 4'h0 || add_b !== 4'h0 || add_cin !== 1'b0 || resp_valid !== 1'b0)
      $display("FAIL midrun_async: add=%h/%h/%b valid=%b required 0/0/0/0",
               add_a, add_b, add_cin, resp_valid);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid) seen++;
    end
    n_total++;
    if (seen != 0) $display("FAIL midrun_discard: resp_valid cycles=%0d required 0", seen);
    else n_pass++;
    @(negedge clk);
    req0_a = 16'h0F0F; req0_b = 16'h0101; req0_cin = 1'b1;
    req1_a = 16'h1111; req1_b = 16'h1111; req1_cin = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    n_total++;
    if ({req0_ready, req1_ready} !== 2'b10)
      $display("FAIL midrun_priority: rdy0/rdy1=%b%b required 10", req0_ready, req1_ready);
    else n_pass++;
    @(posedge clk);
    sb.push_back(model(1'b0, req0_a, req0_b, req0_cin, 1'b0));
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_resp(got, cyc);
    e = (sb.size() > 0) ? sb.pop_front() : mk(1'b1, 16'hDEAD, 1'b1);
    n_total++;
    if (!got || cyc != 4 || resp_sum !== e.sum || resp_cout !== e.cout || resp_id !== e.id)
      $display("FAIL midrun_next: got=%0b edges=%0d sum=%h cout=%b id=%b required 1/4/%h/%b/%b",
               got, cyc, resp_sum, resp_cout, resp_id, e.sum, e.cout, e.id);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

`ifdef ADD4_SCHED_SUB_EN
  task automatic test_sub;
    logic [W-1:0] ta[2] = '{16'h0005, 16'h0003};
    logic [W-1:0] tb[2] = '{16'h0003, 16'h0005};
    logic [W-1:0] ts[2] = '{16'h0002, 16'hFFFE};
    logic         tco[2] = '{1'b1, 1'b0};
    bit ok, got;
    int cyc;
    exp_t e;
    resp_ready = 1'b1;
    sb.delete();
    req0_sub = 1'b1;
    for (int i = 0; i < 2; i++) begin
      send(1'b0, ta[i], tb[i], 1'(i), ok);
      if (ok) sb.push_back(mk(1'b0, ts[i], tco[i]));
      wait_resp(got, cyc);
      e = (sb.size() > 0) ? sb.pop_front() : mk(1'b1, 16'hDEAD, 1'b1);
      n_total++;
      if (!ok || !got || resp_sum !== e.sum || resp_cout !== e.cout)
        $display("FAIL sub_%0d: ok=%0b got=%0b sum=%h cout=%b required %h/%b",
                 i, ok, got, resp_sum, resp_cout, e.sum, e.cout);
      else n_pass++;
      @(posedge clk);
      #1;
    end
    req0_sub = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_add();
    test_carry_chain();
    test_round_robin();
    test_backpressure();
    test_reset_mid_run();
`ifdef ADD4_SCHED_SUB_EN
    test_sub();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
